// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 host-side blocks.
//   ps2_tx_state_t : transmitter FSM states
//   FILT_DEPTH     : number of agreeing samples before a filtered line toggles
//   DEF_*          : default timing constants for a 100 MHz system clock
//   odd_parity()   : PS/2 frame parity bit for a data byte
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK_REL
    } ps2_tx_state_t;

    localparam int FILT_DEPTH = 8;

    localparam int DEF_CLK_FREQ_HZ    = 100_000_000;
    localparam int DEF_INHIBIT_CYCLES = 12_000;     // 120 us request-to-send
    localparam int DEF_TIMEOUT_CYCLES = 2_000_000;  // 20 ms between device edges

    // Odd parity: the 9-bit {par, data} word always carries an odd number of 1s.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Conditions one PS/2 line: 2-flop synchronizer followed by a FILT_DEPTH-sample
// agreement filter. The filtered value only changes once every sample in the
// window agrees; rise/fall are one-cycle pulses aligned with the filtered change.
//   clk   : system clock
//   reset : asynchronous, active-low
//   line  : raw (asynchronous) PS/2 line
//   filt  : filtered line level
//   fall  : one-cycle pulse on a filtered 1->0 transition
//   rise  : one-cycle pulse on a filtered 0->1 transition
// -----------------------------------------------------------------------------
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic filt,
    output logic fall,
    output logic rise
);

    logic [1:0]            sync;
    logic [FILT_DEPTH-1:0] samp;

    // Idle PS/2 lines are pulled high, so everything resets to 1 to avoid a
    // spurious edge when reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            samp <= '1;
            filt <= 1'b1;
            fall <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            samp <= {samp[FILT_DEPTH-2:0], sync[1]};
            fall <= 1'b0;
            rise <= 1'b0;
            if ((&samp) && !filt) begin
                filt <= 1'b1;
                rise <= 1'b1;
            end else if (!(|samp) && filt) begin
                filt <= 1'b0;
                fall <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// -----------------------------------------------------------------------------
// ps2_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the device:
// request-to-send (clock held low), start bit, 8 data bits LSB first, odd
// parity, stop bit, then checks the device's ack bit.
//   clk          : system clock
//   reset        : asynchronous, active-low; releases both lines immediately
//   wr_ps2       : one-cycle start strobe, only accepted while tx_idle=1
//   din          : command byte, latched when wr_ps2 is accepted
//   ps2c, ps2d   : open-drain PS/2 clock/data (driven 0 or released to Z)
//   tx_idle      : 1 while the FSM is in IDLE
//   tx_done_tick : one-cycle pulse, frame acknowledged and bus released
//   tx_err       : one-cycle pulse, watchdog expiry or missing ack
// -----------------------------------------------------------------------------
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int CW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);

    // Timing is expressed directly in clock cycles; the frequency is kept as
    // a documented reference for the cycle counts above.
    localparam int unused_clk_khz = CLK_FREQ_HZ / 1000;

    // ---------------------------------------------------------------- lines
    logic filt_c, fall_c, filt_d;
    logic unused_rise_c, unused_rise_d, unused_fall_d;

    ps2_line_filter u_filt_c (
        .clk   (clk),
        .reset (reset),
        .line  (ps2c),
        .filt  (filt_c),
        .fall  (fall_c),
        .rise  (unused_rise_c)
    );

    ps2_line_filter u_filt_d (
        .clk   (clk),
        .reset (reset),
        .line  (ps2d),
        .filt  (filt_d),
        .fall  (unused_fall_d),
        .rise  (unused_rise_d)
    );

    // ---------------------------------------------------------------- state
    ps2_tx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;       // request-to-send timer
    logic [WW-1:0] wdog, wdog_n;     // time since last device clock edge
    logic [8:0]    sreg, sreg_n;     // {parity, data}, shifted right per bit
    logic [3:0]    n, n_n;           // index of the bit currently on ps2d
    logic          drv_c, drv_c_n;   // 1 = pull ps2c low
    logic          drv_d, drv_d_n;   // 1 = pull ps2d low
    logic          wd_active, wd_hit, abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            wdog  <= '0;
            sreg  <= '0;
            n     <= '0;
            drv_c <= 1'b0;
            drv_d <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wdog  <= wdog_n;
            sreg  <= sreg_n;
            n     <= n_n;
            drv_c <= drv_c_n;
            drv_d <= drv_d_n;
        end
    end

    assign wd_active = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_STOP)  || (state == ST_ACK_REL);
    assign wd_hit    = (wdog == WD_LIMIT);

    always_comb begin
        state_n      = state;
        cnt_n        = '0;
        wdog_n       = '0;
        sreg_n       = sreg;
        n_n          = n;
        drv_c_n      = drv_c;
        drv_d_n      = drv_d;
        tx_done_tick = 1'b0;
        tx_err       = 1'b0;
        abort        = 1'b0;

        // A device edge always reloads the watchdog, even on the expiry cycle.
        if (wd_active)
            wdog_n = fall_c ? '0 : wdog + 1'b1;

        case (state)
            ST_IDLE: begin
                drv_c_n = 1'b0;
                drv_d_n = 1'b0;
                if (wr_ps2) begin
                    sreg_n  = {odd_parity(din), din};
                    drv_c_n = 1'b1;
                    state_n = ST_RTS;
                end
            end

            ST_RTS: begin
                cnt_n = cnt + 1'b1;
                if (cnt == INH_LAST) begin
                    drv_c_n = 1'b0;   // hand the clock to the device
                    drv_d_n = 1'b1;   // start bit
                    cnt_n   = '0;
                    state_n = ST_START;
                end
            end

            ST_START: begin
                if (fall_c) begin
                    drv_d_n = ~sreg[0];
                    n_n     = 4'd0;
                    state_n = ST_DATA;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end

            ST_DATA: begin
                if (fall_c) begin
                    if (n == 4'd8) begin
                        // Parity has been sent: release data as the stop bit.
                        drv_d_n = 1'b0;
                        state_n = ST_STOP;
                    end else begin
                        sreg_n  = {1'b0, sreg[8:1]};
                        drv_d_n = ~sreg[1];
                        n_n     = n + 4'd1;
                    end
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end

            ST_STOP: begin
                if (fall_c) begin
                    if (!filt_d) begin
                        state_n = ST_ACK_REL;
                    end else begin
                        tx_err  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end

            ST_ACK_REL: begin
                if (filt_c && filt_d) begin
                    tx_done_tick = 1'b1;
                    state_n      = ST_IDLE;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                drv_c_n = 1'b0;
                drv_d_n = 1'b0;
            end
        endcase

        if (abort) begin
            drv_c_n = 1'b0;
            drv_d_n = 1'b0;
            wdog_n  = '0;
            tx_err  = 1'b1;
            state_n = ST_IDLE;
        end
    end

    assign tx_idle = (state == ST_IDLE);

    // Open-drain drivers: only ever pull low or release.
    assign ps2c = drv_c ? 1'b0 : 1'bz;
    assign ps2d = drv_d ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_tx
// Directed bench for ps2_tx with a simple PS/2 device model on pulled-up lines.
// Short inhibit/timeout values keep the run compact; the device clocks with a
// 50-cycle half period.
// -----------------------------------------------------------------------------
module tb_ps2_tx;

    localparam int INH = 1200;
    localparam int TO  = 5000;
    localparam int H   = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c = 1'b0;
    logic       dev_d = 1'b0;
    logic       tx_idle, tx_done_tick, tx_err;
    wire        ps2c, ps2d;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_tx #(
        .CLK_FREQ_HZ    (100_000_000),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err       (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt++;
        if (tx_err)       err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_d_low(input int lim, input string tag, output int t);
        int k;
        k = 0;
        while (ps2d !== 1'b0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        check({tag, " start-bit wait"}, 32'(k < lim), 1);
        t = cyc;
    endtask

    task automatic dev_edge(output logic b);
        dev_c = 1'b1;
        repeat (H) @(negedge clk);
        b = ps2d;
        dev_c = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] b8, input string tag, output int t_start);
        int t_c;
        @(negedge clk);
        din = b8;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check({tag, " idle drop"}, 32'(tx_idle), 0);
        check({tag, " rts clk low"}, 32'(ps2c), 0);
        t_c = cyc;
        wait_d_low(INH + 20, tag, t_start);
        check({tag, " inhibit length"}, t_start - t_c, INH);
        check({tag, " clk released at start"}, 32'(ps2c), 1);
    endtask

    task automatic run_frame(input logic [7:0] b8, input logic ack, input logic repulse,
                             input logic [10:0] exp_bits, input string tag);
        logic [10:0] bits;
        logic        b;
        int          t0, d0, e0, k;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b8, tag, t0);
        bits = '0;
        bits[0] = ps2d;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_edge(b);
            bits[i] = b;
            if (repulse && i == 3) begin
                din = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                din = b8;
                check({tag, " busy stays busy"}, 32'(tx_idle), 0);
            end
        end
        // 11th edge: device pulls data low (ack) ahead of its clock pulse.
        dev_d = ack;
        repeat (H / 2) @(negedge clk);
        dev_c = 1'b1;
        repeat (H) @(negedge clk);
        dev_c = 1'b0;
        repeat (H) @(negedge clk);
        dev_d = 1'b0;
        k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check({tag, " frame bits"}, 32'(bits), 32'(exp_bits));
        check({tag, " done pulses"}, done_cnt - d0, ack ? 1 : 0);
        check({tag, " err pulses"}, err_cnt - e0, ack ? 0 : 1);
        check({tag, " idle after"}, 32'(tx_idle), 1);
    endtask

    initial begin
        int   t0, d0, e0, k;
        logic b;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx_idle", 32'(tx_idle), 1);
        check("reset done", 32'(tx_done_tick), 0);
        check("reset err", 32'(tx_err), 0);
        check("reset ps2c released", 32'(ps2c), 1);
        check("reset ps2d released", 32'(ps2d), 1);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Frames {stop, parity, data, start}; parities worked by hand
        run_frame(8'hF4, 1'b1, 1'b0, 11'b1_0_11110100_0, "F4");
        run_frame(8'hED, 1'b1, 1'b0, 11'b1_1_11101101_0, "ED");
        run_frame(8'h00, 1'b1, 1'b0, 11'b1_1_00000000_0, "00");
        run_frame(8'hFF, 1'b1, 1'b0, 11'b1_1_11111111_0, "FF");
        run_frame(8'h01, 1'b1, 1'b0, 11'b1_0_00000001_0, "01");

        // Missing ack, then a normal frame
        run_frame(8'hF4, 1'b0, 1'b0, 11'b1_0_11110100_0, "nack");
        run_frame(8'hFF, 1'b1, 1'b0, 11'b1_1_11111111_0, "after nack");

        // Strobe while busy is dropped
        run_frame(8'h3C, 1'b1, 1'b1, 11'b1_1_00111100_0, "repulse");

        // Device never clocks: watchdog expiry
        d0 = done_cnt;
        start_tx(8'hF4, "timeout", t0);
        k = 0;
        while (tx_err !== 1'b1 && k < TO + 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout seen", 32'(k < TO + 100), 1);
        check("timeout latency", cyc - t0, TO);
        @(negedge clk);
        check("timeout ps2c released", 32'(ps2c), 1);
        check("timeout ps2d released", 32'(ps2d), 1);
        check("timeout idle", 32'(tx_idle), 1);
        check("timeout no done", done_cnt - d0, 0);
        repeat (20) @(negedge clk);

        // Reset mid-DATA: d3 of 0x96 is 0, so data is being pulled low
        e0 = err_cnt;
        start_tx(8'h96, "rst", t0);
        repeat (H) @(negedge clk);
        for (int i = 1; i <= 4; i++) dev_edge(b);
        check("rst data driven", 32'(ps2d), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst ps2d released", 32'(ps2d), 1);
        check("rst ps2c released", 32'(ps2c), 1);
        check("rst idle", 32'(tx_idle), 1);
        check("rst no err", err_cnt - e0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        run_frame(8'hF4, 1'b1, 1'b0, 11'b1_0_11110100_0, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: the outbound counterpart of the keyboard receiver already in the input path. It sends one command byte to the keyboard over the shared `ps2c`/`ps2d` open-drain lines. Typical commands are 0xFF (reset), 0xED (set LEDs) and 0xF4 (enable). It sits beside the receiver in the top-level controller. The top level holds the receiver's `rx_en` low whenever `tx_idle` is 0.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `INHIBIT_CYCLES`, 12_000: request-to-send clock-low time (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 2_000_000: watchdog limit between device clock edges (20 ms). The counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_ps2`  in  1  one-cycle start strobe. Sampled only while `tx_idle`=1.
- `din`  in  8  command byte, latched on an accepted `wr_ps2`.
- `ps2c`  inout  1  PS/2 clock. The block only drives 0 or releases to Z.
- `ps2d`  inout  1  PS/2 data. The block only drives 0 or releases to Z.
- `tx_idle`  out  1  1 when the FSM is in IDLE.
- `tx_done_tick`  out  1  one-cycle pulse when a frame is acknowledged and the bus is released.
- `tx_err`  out  1  one-cycle pulse on watchdog expiry or missing ack.

## Operation
- Line conditioning:
  - Each line passes through a 2-flop synchronizer and then an 8-sample filter.
  - The filtered value changes only when 8 consecutive samples agree.
  - `fall_c` is a one-cycle pulse on a filtered `ps2c` 1→0 transition.
- On an accepted `wr_ps2`, the block latches `din` and odd parity `par = ~^din`, giving a 9-bit shift register `{par, din}`.
- States:
  - IDLE: both lines released. On `wr_ps2` → RTS, counter cleared.
  - RTS: drive `ps2c`=0 and keep `ps2d` released. At count = `INHIBIT_CYCLES-1` → START.
  - START: release `ps2c`, drive `ps2d`=0 (start bit), reload watchdog. On `fall_c` → DATA, put bit 0 on `ps2d`, n=0.
  - DATA: on each `fall_c`, shift right and put the next bit on `ps2d`. Driving 1 means releasing the line. After the 9th bit (parity) is placed, the next `fall_c` releases `ps2d` (stop bit) → STOP.
  - STOP: on `fall_c`, sample filtered `ps2d`. A 0 is a valid ack → ACK_REL. A 1 is a missing ack → `tx_err`, then IDLE.
  - ACK_REL: wait for filtered `ps2c`=1 and `ps2d`=1 → `tx_done_tick`, then IDLE.
- Edge count: exactly 11 device falling edges per frame (start-release, d0..d7, parity, stop/ack).
- Watchdog:
  - Counts in START, DATA, STOP and ACK_REL, and reloads on every `fall_c`.
  - On reaching `TIMEOUT_CYCLES`: release both lines, pulse `tx_err`, go to IDLE.
- Incoming device traffic while in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE, `tx_idle`=1, `tx_done_tick`=0, `tx_err`=0.
  - Both line drivers released (Z), all counters 0.
- Reset asserted mid-frame releases both lines immediately, asynchronously. There is no error pulse.
- `tx_idle` falls on the cycle after `wr_ps2` is accepted.
- `ps2c` is driven low for exactly `INHIBIT_CYCLES` clocks.
- Data changes occur on the cycle after `fall_c`. The edge detect adds ~10 clk of latency, which is negligible against the ≥30 µs device half-period.
- `wr_ps2` while busy is dropped; `din` is not re-latched.
- `tx_done_tick` and `tx_err` are mutually exclusive and never both pulse for one frame. `tx_idle` rises on the cycle after either pulse.
- `fall_c` coinciding with watchdog expiry: the edge wins and the watchdog reloads.

## Structure
- Package `ps2_pkg`:
  - State enum `ps2_tx_state_t`.
  - Filter depth constant (8).
  - Default timing constants.
  - Parity helper function.
- Sub-module `ps2_line_filter`: synchronizer, 8-sample filter, and rise/fall pulses. Two instances, one for `ps2c` and one for `ps2d`. It is reusable by the receiver.
- Tri-state drivers live in `ps2_tx`, written as `assign ps2c = drv_c ? 1'b0 : 1'bz`.

## Test plan
- `din`=0xF4, device model clocks at 12.5 kHz and acks → frame observed as start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one `tx_done_tick`; `tx_idle` returns to 1.
- `din`=0xED and 0x00 → parity bit 1 in both cases; 0xFF → parity 1; 0x01 → parity 0.
- `INHIBIT_CYCLES`=12_000 → `ps2c` is low for exactly 12_000 clk before `ps2d` falls.
- Device never clocks, with `TIMEOUT_CYCLES` overridden to 5_000 → `tx_err` pulses at 5_000 clk after START, both lines at Z, no `tx_done_tick`.
- Device holds `ps2d` high at the 11th edge → `tx_err`, IDLE; a following `wr_ps2`=0xFF completes normally.
- `wr_ps2` pulsed again mid-DATA with `din`=0x55 → transmitted byte is unchanged; `reset`=0 asserted mid-DATA → lines released within 1 clk, `tx_idle`=1.
